// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: round-robin arbiter sharing one FIFO write port among N_REQ producers.
// The winner's word is registered into a single output stage that honours FIFO backpressure.
// Optional burst mode (up to BURST_LEN consecutive grants to one requester) is enabled by
// defining FIFO_ARB_BURST_EN.
module fifo_write_arbiter #(
    parameter int N_REQ     = 4,
    parameter int DATA_W    = 16,
    parameter int BURST_LEN = 4,
    parameter int IDX_W     = $clog2(N_REQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        req_ready,
    output logic [DATA_W-1:0]       fifo_data_in,
    output logic                    fifo_input_valid,
    input  logic                    fifo_input_enable,
    output logic [IDX_W-1:0]        grant_id
);

    // Elaboration-time parameter sanity checks
    if (N_REQ < 2 || N_REQ > 8 || (N_REQ & (N_REQ - 1)) != 0) begin : g_bad_n_req
        $error("fifo_write_arbiter: N_REQ must be a power of two in 2..8");
    end
    if (BURST_LEN < 2 || BURST_LEN > 16) begin : g_bad_burst_len
        $error("fifo_write_arbiter: BURST_LEN must be in 2..16");
    end

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [IDX_W-1:0]  grant_q, grant_d;
    logic [IDX_W-1:0]  last_q, last_d;

    logic              load_ok;
    logic              rr_found;
    logic [IDX_W-1:0]  rr_idx;
    logic              win_found;
    logic [IDX_W-1:0]  win_idx;
    logic [DATA_W-1:0] win_data;

`ifdef FIFO_ARB_BURST_EN
    localparam int CNT_W = $clog2(BURST_LEN);
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    // Set once a real grant has happened, so the reset value of last_q never sticks
    logic              live_q, live_d;
    logic              stick;
`endif

    // Round-robin search starting just after the last granted requester
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = last_q;
        for (int k = 1; k <= N_REQ; k++) begin
            if (!rr_found && req_valid[last_q + IDX_W'(k)]) begin
                rr_found = 1'b1;
                rr_idx   = last_q + IDX_W'(k);
            end
        end
    end

    // Winner selection, optionally keeping the current requester for a burst
    always_comb begin
        win_found = rr_found;
        win_idx   = rr_idx;
`ifdef FIFO_ARB_BURST_EN
        stick = live_q && req_valid[last_q] && (cnt_q < CNT_W'(BURST_LEN - 1));
        if (stick) begin
            win_found = 1'b1;
            win_idx   = last_q;
        end
`endif
        win_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win_idx == IDX_W'(i)) begin
                win_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Handshake and output-stage next state
    always_comb begin
        load_ok     = !out_valid_q || fifo_input_enable;
        req_ready   = '0;
        out_valid_d = out_valid_q;
        data_d      = data_q;
        grant_d     = grant_q;
        last_d      = last_q;
        if (load_ok) begin
            if (win_found) begin
                req_ready[win_idx] = !rst;
                out_valid_d        = 1'b1;
                data_d             = win_data;
                grant_d            = win_idx;
                last_d             = win_idx;
            end else begin
                // load_ok with a held word implies it drains this edge
                out_valid_d = 1'b0;
            end
        end
    end

`ifdef FIFO_ARB_BURST_EN
    // Burst counter next state; stalled cycles leave it untouched
    always_comb begin
        cnt_d  = cnt_q;
        live_d = live_q;
        if (load_ok) begin
            cnt_d  = stick ? cnt_q + CNT_W'(1) : '0;
            live_d = win_found;
        end
    end

    // Burst counter state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            live_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            live_q <= live_d;
        end
    end
`endif

    // Output stage and arbitration pointer state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            data_q      <= '0;
            grant_q     <= '0;
            last_q      <= IDX_W'(N_REQ - 1);
        end else begin
            out_valid_q <= out_valid_d;
            data_q      <= data_d;
            grant_q     <= grant_d;
            last_q      <= last_d;
        end
    end

    assign fifo_input_valid = out_valid_q;
    assign fifo_data_in     = data_q;
    assign grant_id         = grant_q;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb_fifo_write_arbiter: directed self-checking bench for fifo_write_arbiter (N_REQ=4, DATA_W=16).
module tb_fifo_write_arbiter;

    localparam int N = 4;
    localparam int W = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic [W-1:0]   fifo_data_in;
    logic           fifo_input_valid;
    logic           fifo_input_enable;
    logic [1:0]     grant_id;

    int n_checks = 0;
    int n_pass   = 0;

    fifo_write_arbiter #(
        .N_REQ    (N),
        .DATA_W   (W),
        .BURST_LEN(4)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .req_valid        (req_valid),
        .req_data         (req_data),
        .req_ready        (req_ready),
        .fifo_data_in     (fifo_data_in),
        .fifo_input_valid (fifo_input_valid),
        .fifo_input_enable(fifo_input_enable),
        .grant_id         (grant_id)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int i, input logic [W-1:0] v);
        req_data[i*W +: W] = v;
    endtask

    task automatic base_data();
        for (int i = 0; i < N; i++) set_data(i, 16'(16'h1000 + i));
    endtask

    initial begin
        rst               = 1'b0;
        req_valid         = 4'hF;
        fifo_input_enable = 1'b1;
        req_data          = '0;
        base_data();

        // Reset with all requesters valid
        #2 rst = 1'b1;
        #1;
        check("rst_valid", 32'(fifo_input_valid), 32'h0);
        check("rst_ready", 32'(req_ready), 32'h0);
        check("rst_grant", 32'(grant_id), 32'h0);
        check("rst_data", 32'(fifo_data_in), 32'h0);
        tick();
        tick();
        check("rst_hold_valid", 32'(fifo_input_valid), 32'h0);
        check("rst_hold_ready", 32'(req_ready), 32'h0);
        rst = 1'b0;
        #1;
        check("first_ready", 32'(req_ready), 32'h1);

`ifdef FIFO_ARB_BURST_EN
        // Burst: 0,0,0,0,1,1 then requester 1 drops and 2 takes over
        begin
            int exp_g [6] = '{0, 0, 0, 0, 1, 1};
            for (int c = 0; c < 6; c++) begin
                tick();
                check("burst_grant", 32'(grant_id), 32'(exp_g[c]));
                check("burst_data", 32'(fifo_data_in), 32'(16'h1000 + exp_g[c]));
            end
            req_valid = 4'b1101;
            tick();
            check("burst_drop_grant", 32'(grant_id), 32'h2);
            check("burst_drop_data", 32'(fifo_data_in), 32'h1002);
        end
`else
        // Full rate round robin, one word per cycle
        for (int c = 0; c < 8; c++) begin
            tick();
            check("full_grant", 32'(grant_id), 32'(c % 4));
            check("full_data", 32'(fifo_data_in), 32'(16'h1000 + (c % 4)));
            check("full_valid", 32'(fifo_input_valid), 32'h1);
            check("full_ready", 32'(req_ready), 32'(1) << ((c + 1) % 4));
        end
`endif

        // Backpressure: fresh reset, load 0xA5A5 from requester 0, then stall
        rst = 1'b1;
        req_valid = 4'b0001;
        set_data(0, 16'hA5A5);
        tick();
        rst = 1'b0;
        tick();
        check("bp_load_data", 32'(fifo_data_in), 32'hA5A5);
        check("bp_load_grant", 32'(grant_id), 32'h0);
        fifo_input_enable = 1'b0;
        req_valid         = 4'b0110;
        set_data(1, 16'h2001);
        set_data(2, 16'h2002);
        #1;
        check("bp_ready0", 32'(req_ready), 32'h0);
        for (int c = 0; c < 5; c++) begin
            tick();
            check("bp_hold_data", 32'(fifo_data_in), 32'hA5A5);
            check("bp_hold_valid", 32'(fifo_input_valid), 32'h1);
            check("bp_hold_ready", 32'(req_ready), 32'h0);
        end
        fifo_input_enable = 1'b1;
        #1;
        check("bp_release_ready", 32'(req_ready), 32'h2);
        tick();
        check("bp_next_data", 32'(fifo_data_in), 32'h2001);
        check("bp_next_grant", 32'(grant_id), 32'h1);
        check("bp_next_valid", 32'(fifo_input_valid), 32'h1);

`ifndef FIFO_ARB_BURST_EN
        // Rotation: only 2 valid for three cycles, then 1 joins
        begin
            int exp_g [6] = '{2, 2, 2, 1, 2, 1};
            req_valid = 4'b0100;
            set_data(1, 16'h3001);
            set_data(2, 16'h3002);
            for (int c = 0; c < 6; c++) begin
                if (c == 3) req_valid = 4'b0110;
                tick();
                check("rot_grant", 32'(grant_id), 32'(exp_g[c]));
                check("rot_data", 32'(fifo_data_in), 32'(16'h3000 + exp_g[c]));
            end
        end
`endif

        // Reset mid-stream while requester 3's word is held
        req_valid = 4'b1000;
        set_data(3, 16'h4003);
        tick();
        check("mid_grant", 32'(grant_id), 32'h3);
        check("mid_valid", 32'(fifo_input_valid), 32'h1);
        fifo_input_enable = 1'b0;
        req_valid         = 4'b0000;
        #2 rst = 1'b1;
        #1;
        check("mid_async_valid", 32'(fifo_input_valid), 32'h0);
        check("mid_async_grant", 32'(grant_id), 32'h0);
        check("mid_async_data", 32'(fifo_data_in), 32'h0);
        tick();
        base_data();
        req_valid         = 4'hF;
        fifo_input_enable = 1'b1;
        rst               = 1'b0;
        #1;
        check("post_rst_ready", 32'(req_ready), 32'h1);
        tick();
        check("post_rst_grant", 32'(grant_id), 32'h0);
        check("post_rst_data", 32'(fifo_data_in), 32'h1000);

        // Drain with no requesters: valid falls, data and grant hold
        req_valid = 4'b0000;
        #1;
        check("idle_ready", 32'(req_ready), 32'h0);
        tick();
        check("drain_valid", 32'(fifo_input_valid), 32'h0);
        check("drain_data", 32'(fifo_data_in), 32'h1000);
        check("drain_grant", 32'(grant_id), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fifo_write_arbiter.md
# fifo_write_arbiter

Round-robin arbiter that shares the write port of the 16-bit-in / 8-bit-out FIFO among several producers. Each producer offers a word with a valid/ready handshake. The arbiter selects one per cycle and registers it into a single output stage. That stage drives the FIFO's `input_valid`/`data_in` and honours the FIFO's `input_enable` backpressure. The block sits entirely in the FIFO write-clock domain.

## Interface
- `N_REQ`, default 4: number of requesters; power of two, 2..8.
- `DATA_W`, default 16: word width; matches FIFO `data_in`.
- `BURST_LEN`, default 4: maximum consecutive grants to one requester; used only when the burst feature is compiled in; range 2..16.
- `IDX_W`, default `$clog2(N_REQ)`: derived; not overridden.

Ports:
- `clk`  in  1: FIFO write clock; all state updates on rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `req_valid`  in  `N_REQ`: bit i set = requester i offers a word.
- `req_data`  in  `N_REQ*DATA_W`: requester i word at bits `[i*DATA_W +: DATA_W]`.
- `req_ready`  out  `N_REQ`: one-hot or zero, combinational; bit i set = requester i's word is taken at this edge.
- `fifo_data_in`  out  `DATA_W`: registered word to FIFO `data_in`.
- `fifo_input_valid`  out  1: output register holds a word; to FIFO `input_valid`.
- `fifo_input_enable`  in  1: FIFO accepts a word this cycle; from FIFO `input_enable`.
- `grant_id`  out  `IDX_W`: index of the requester whose word is currently in the output register.

## Operation
- Output stage:
  - `out_valid` register drives `fifo_input_valid`.
  - A drain occurs when `out_valid && fifo_input_enable`.
  - `load_ok = !out_valid || fifo_input_enable`.
- Arbitration:
  - Evaluated only when `load_ok`; otherwise `req_ready = 0`.
  - `last` register holds the last granted index.
  - Search order is `last+1, last+2, …` mod `N_REQ`.
  - The first requester with `req_valid` set wins: its `req_ready` = 1.
  - At the edge, `fifo_data_in` ← winner's data, `grant_id` ← winner, `last` ← winner, `out_valid` ← 1.
- If `load_ok` and no `req_valid`: `out_valid` ← 0 when drained, otherwise unchanged. `fifo_data_in` and `grant_id` hold.
- Simultaneous drain and load in the same cycle is legal: sustained throughput is 1 word/cycle.
- A held word is never modified or dropped while `fifo_input_valid && !fifo_input_enable`.
- Requesters may deassert `req_valid` at any time. No word is lost, because a transfer requires `req_ready` in the same cycle.

## Timing
- Reset values:
  - `fifo_input_valid` = 0
  - `fifo_data_in` = 0
  - `grant_id` = 0
  - `last` = `N_REQ-1`, so requester 0 has first priority
  - burst counter = 0
- `req_ready` is 0 while `rst` is high.
- Latency: a word accepted at edge t appears on `fifo_data_in` with `fifo_input_valid` = 1 after edge t. It is consumed by the FIFO at the first edge where `fifo_input_enable` = 1.
- `req_ready` depends combinationally on `req_valid`, `fifo_input_enable`, `out_valid` and `last`. There is no combinational path from `req_data`.
- Reset mid-operation: the held word is discarded and outputs clear immediately (asynchronously). After release, priority restarts at requester 0.
- Round-robin fairness: with all requesters continuously valid and no backpressure, each is granted once per `N_REQ` cycles.

## Configuration
- Macro `FIFO_ARB_BURST_EN`.
- Defined:
  - A `$clog2(BURST_LEN)`-bit counter tracks consecutive grants to `last`.
  - If `req_valid[last]` is set and count < `BURST_LEN-1`, `last` is granted again and the counter increments.
  - Otherwise normal round-robin applies and the counter resets to 0.
  - The counter also resets when `req_valid[last]` drops.
  - Stalled cycles (`!load_ok`) do not advance the counter.
- Undefined: no counter exists; pure per-word round-robin as above.

## Test plan
- Reset: assert `rst` with all `req_valid` = 1 → `fifo_input_valid` = 0, `req_ready` = 0, `grant_id` = 0, `fifo_data_in` = 0x0000. First grant after release goes to requester 0.
- Full rate, macro undefined: all four valid, data `0x1000+i`, `fifo_input_enable` = 1 → `fifo_data_in` sequence 0x1000, 0x1001, 0x1002, 0x1003, 0x1000, … one per cycle, `grant_id` matching.
- Backpressure: word 0xA5A5 held, `fifo_input_enable` = 0 for 5 cycles → `fifo_data_in` = 0xA5A5, `fifo_input_valid` = 1 and `req_ready` = 0 throughout. Enable = 1 → next winner loaded at the same edge 0xA5A5 drains.
- Rotation: only requester 2 valid for 3 cycles, then requester 1 also valid → grants 2, 2, 2, then 1, then 2, 1 alternating.
- Burst, `FIFO_ARB_BURST_EN` defined, `BURST_LEN` = 4: all valid → `grant_id` 0,0,0,0,1,1,1,1,2,…. Dropping `req_valid[1]` after its 2nd grant → switch to 2 on the next cycle.
- Reset mid-stream: `rst` pulsed while `fifo_input_valid` = 1 and `grant_id` = 3 → `fifo_input_valid` falls without a clock edge. After release, requester 0 is granted first.
